scalar_mult_scheduler: RTL and testbench

Sequences left-to-right double-and-add scalar multiplication over the point add/double engine. It scans a latched scalar MSB to LSB and issues one point-double or point-add command at a time on the engine's 2-bit command bus. For each command it waits for the matching interrupt before moving on. It sits between the host/control layer and the point-operation state machine; the host preloads P and Q = P in engine RAM before start.

---
 rtl/scalar_mult_scheduler.sv | 169 ++++++++++++++++
 tb/tb_scalar_mult_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_scheduler.sv
// Left-to-right double-and-add sequencer driving the point add/double engine command bus.
// Optional per-operation watchdog: define SCALAR_MULT_TIMEOUT_EN.
module scalar_mult_scheduler #(
  parameter int KEY_W   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] scalar,
  input  logic [9:0]       scalar_len,
  output logic [1:0]       command,
  input  logic             interupt_point_double,
  input  logic             interupt_point_addition,
  output logic             busy,
  output logic             done,
  output logic             zero_scalar,
  output logic [9:0]       bit_idx,
  output logic [9:0]       op_count,
  output logic             timeout_err,
  output logic [2:0]       state_dbg_o
);

  localparam int          IDX_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [9:0]  KEY_W_10 = 10'(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL_WAIT, S_GAP_D, S_ADD_WAIT, S_GAP_A, S_NEXT, S_DONE
  } state_e;

  // Handshake: each non-zero command is held until its own interrupt is sampled
  // high while already in the matching WAIT state; every other interrupt is ignored.
  state_e           state_q, state_d;
  logic [KEY_W-1:0] scalar_q, scalar_d;
  logic [9:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       op_count_q, op_count_d;
  logic             zero_q, zero_d;
  logic             terr_q, terr_d;
  logic [9:0]       eff_len;
  logic             cur_bit;

`ifdef SCALAR_MULT_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  assign eff_len = (scalar_len > KEY_W_10) ? KEY_W_10 : scalar_len;
  assign cur_bit = scalar_q[bit_idx_q[IDX_W-1:0]];

  always_comb begin
    state_d    = state_q;
    scalar_d   = scalar_q;
    bit_idx_d  = bit_idx_q;
    op_count_d = op_count_q;
    zero_d     = zero_q;
    terr_d     = terr_q;
`ifdef SCALAR_MULT_TIMEOUT_EN
    tmr_d      = tmr_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            scalar_d   = scalar;
            op_count_d = '0;
            zero_d     = 1'b0;
            terr_d     = 1'b0;
            if (eff_len == 10'd0) begin
              zero_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              bit_idx_d = eff_len - 10'd1;
              state_d   = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (bit_idx_q == 10'd0) begin
            zero_d  = ~cur_bit;
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q - 10'd1;
            if (cur_bit) state_d = S_DBL_WAIT;
          end
        end
        S_DBL_WAIT: begin
          if (interupt_point_double) state_d = S_GAP_D;
`ifdef SCALAR_MULT_TIMEOUT_EN
          else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = S_DONE;
          end else tmr_d = tmr_q + 1'b1;
`endif
        end
        S_GAP_D: state_d = cur_bit ? S_ADD_WAIT : S_NEXT;
        S_ADD_WAIT: begin
          if (interupt_point_addition) state_d = S_GAP_A;
`ifdef SCALAR_MULT_TIMEOUT_EN
          else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = S_DONE;
          end else tmr_d = tmr_q + 1'b1;
`endif
        end
        S_GAP_A: state_d = S_NEXT;
        S_NEXT: begin
          if (bit_idx_q == 10'd0) begin
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q - 10'd1;
            state_d   = S_DBL_WAIT;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      // Count each command once, on the edge that enters its WAIT state.
      if ((state_d == S_DBL_WAIT && state_q != S_DBL_WAIT) ||
          (state_d == S_ADD_WAIT && state_q != S_ADD_WAIT)) begin
        op_count_d = op_count_q + 10'd1;
`ifdef SCALAR_MULT_TIMEOUT_EN
        tmr_d      = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      scalar_q   <= '0;
      bit_idx_q  <= '0;
      op_count_q <= '0;
      zero_q     <= 1'b0;
      terr_q     <= 1'b0;
`ifdef SCALAR_MULT_TIMEOUT_EN
      tmr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scalar_q   <= scalar_d;
      bit_idx_q  <= bit_idx_d;
      op_count_q <= op_count_d;
      zero_q     <= zero_d;
      terr_q     <= terr_d;
`ifdef SCALAR_MULT_TIMEOUT_EN
      tmr_q      <= tmr_d;
`endif
    end
  end

  assign command     = (state_q == S_DBL_WAIT) ? 2'b01 :
                       (state_q == S_ADD_WAIT) ? 2'b10 : 2'b00;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign zero_scalar = zero_q;
  assign bit_idx     = bit_idx_q;
  assign op_count    = op_count_q;
  assign state_dbg_o = state_q;
`ifdef SCALAR_MULT_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_scalar_mult_scheduler.sv
// Randomized scoreboard bench for scalar_mult_scheduler with a reactive engine model.
module tb_scalar_mult_scheduler;
  localparam int KEY_W   = 32;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [KEY_W-1:0] scalar = '0;
  logic [9:0]       scalar_len = '0;
  logic [1:0]       command;
  logic             int_dbl = 1'b0;
  logic             int_add = 1'b0;
  logic             busy, done, zero_scalar, timeout_err;
  logic [9:0]       bit_idx, op_count;
  logic [2:0]       state_dbg;

  scalar_mult_scheduler #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .scalar(scalar), .scalar_len(scalar_len), .command(command),
    .interupt_point_double(int_dbl), .interupt_point_addition(int_add),
    .busy(busy), .done(done), .zero_scalar(zero_scalar), .bit_idx(bit_idx),
    .op_count(op_count), .timeout_err(timeout_err), .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   eng_lat = 3;
  bit   eng_en = 1'b1;
  logic [1:0] exp_q[$];
  logic [9:0] exp_opc_q[$];
  logic       exp_zero_q[$];
  logic       exp_terr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the command list of left-to-right double-and-add over the
  // significant bits; returns the expected start-to-done cycle count.
  function automatic int model(input logic [KEY_W-1:0] k, input logic [9:0] len, input bit push_done);
    int l, m, nops;
    l = (int'(len) > KEY_W) ? KEY_W : int'(len);
    m = -1;
    for (int i = 0; i < l; i++) if (k[i]) m = i;
    nops = 0;
    for (int i = m - 1; i >= 0; i--) begin
      exp_q.push_back(2'b01); nops++;
      if (k[i]) begin exp_q.push_back(2'b10); nops++; end
    end
    if (push_done) begin
      exp_opc_q.push_back(10'(nops));
      exp_zero_q.push_back(m < 0);
      exp_terr_q.push_back(1'b0);
    end
    if (m < 0) return l + 1;
    return (l - m) + nops * (eng_lat + 1) + m + 1;
  endfunction

  // engine model: answers each new command after eng_lat cycles
  initial begin : engine
    logic [1:0] prev, typ;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (eng_en && rst_n && command != 2'b00 && prev == 2'b00) begin
        typ = command;
        repeat (eng_lat - 1) @(negedge clk);
        if (rst_n && command == typ) begin
          if (typ == 2'b01) begin
            int_dbl = 1'b1; @(negedge clk); int_dbl = 1'b0;
          end else begin
            int_add = 1'b1; @(negedge clk); int_add = 1'b0;
          end
        end
      end
      prev = command;
    end
  end

  // monitor: pops the scoreboard whenever a command starts or done pulses
  initial begin : monitor
    logic [1:0] prev_cmd;
    prev_cmd = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_cmd = 2'b00;
      else begin
        if (command == 2'b11) check("cmd_illegal", 32'(command), 32'd0);
        if (command != 2'b00 && prev_cmd == 2'b00) begin
          if (exp_q.size() == 0) check("unexpected_cmd", 32'(command), 32'd0);
          else check("cmd", 32'(command), 32'(exp_q.pop_front()));
        end
        if (done) begin
          if (exp_opc_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
          else begin
            check("op_count", 32'(op_count), 32'(exp_opc_q.pop_front()));
            check("zero_scalar", 32'(zero_scalar), 32'(exp_zero_q.pop_front()));
            check("timeout_err", 32'(timeout_err), 32'(exp_terr_q.pop_front()));
            check("busy_at_done", 32'(busy), 32'd0);
            check("cmd_at_done", 32'(command), 32'd0);
          end
        end
        prev_cmd = command;
      end
    end
  end

  task automatic wait_done(input string tag, input int lat_exp);
    int cyc;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    if (lat_exp > 0) check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
    @(negedge clk);
    check({tag, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_op(input logic [KEY_W-1:0] k, input logic [9:0] len, input string tag);
    int lat_exp;
    lat_exp = model(k, len, 1'b1);
    @(negedge clk); scalar = k; scalar_len = len; start = 1'b1;
    wait_done(tag, lat_exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_command"}, 32'(command), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_zero"}, 32'(zero_scalar), 32'd0);
    check({tag, "_bit_idx"}, 32'(bit_idx), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int dummy;
    logic [KEY_W-1:0] k;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    eng_lat = 5;
    run_op(32'hB, 10'd4, "k_0xB");
    run_op(32'h1, 10'd8, "k_1");
    run_op(32'h0, 10'd16, "k_0");
    run_op(32'h5, 10'd0, "len_0");
    eng_lat = 2;
    run_op(32'hFFFF_FFFF, 10'd40, "clamp");

    // abort during the second double
    eng_lat = 5;
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    @(negedge clk); scalar = 32'hB; scalar_len = 10'd4; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (!(op_count == 10'd2 && command == 2'b01) && cyc < 200) begin @(negedge clk); cyc++; end
    check("abort_reach_dbl2", 32'(op_count), 32'd2);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_command", 32'(command), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_op_count", 32'(op_count), 32'd2);
    repeat (8) @(negedge clk);
    check("abort_cmds_left", 32'(exp_q.size()), 32'd0);
    // abort beats start in IDLE
    scalar = 32'h7; scalar_len = 10'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    run_op(32'hB, 10'd4, "after_abort");

    // spurious add interrupt and start while busy
    fork
      run_op(32'hB, 10'd4, "spurious");
      begin
        cyc = 0;
        while (command != 2'b01 && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        int_add = 1'b1; start = 1'b1; scalar = 32'hFFFF; scalar_len = 10'd16;
        @(negedge clk);
        int_add = 1'b0; start = 1'b0;
      end
    join

    // reset in the middle of an add
    dummy = model(32'hB, 10'd4, 1'b0);
    @(negedge clk); scalar = 32'hB; scalar_len = 10'd4; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (command != 2'b10 && cyc < 200) begin @(negedge clk); cyc++; end
    check("reset_reach_add", 32'(command), 32'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SCALAR_MULT_TIMEOUT_EN
    eng_en = 1'b0;
    exp_q.push_back(2'b01);
    exp_opc_q.push_back(10'd1); exp_zero_q.push_back(1'b0); exp_terr_q.push_back(1'b1);
    @(negedge clk); scalar = 32'hB; scalar_len = 10'd4; start = 1'b1;
    wait_done("timeout", 1 + TIMEOUT + 1);
    check("timeout_err_hold", 32'(timeout_err), 32'd1);
    eng_en = 1'b1;
`endif

    for (int r = 0; r < 12; r++) begin
      eng_lat = $urandom_range(1, 6);
      k = $urandom;
      if (r % 3 == 0) k = k >> $urandom_range(20, 31);
      run_op(k, 10'($urandom_range(0, 36)), "random");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
